// File: rtl/des_sbox_bank.sv
// DES S-box lookup bank: one writable 64x4 S-box table shared by LANES
// parallel lookup lanes. A config port edits and reads back entries, and a
// restore sequence reloads the standard FIPS 46-3 table one entry per cycle.
//
// Handshakes: a transfer on either side happens on a rising edge where valid
// and ready are both high. in_ready does not depend on in_valid. Once
// out_valid is raised, out_valid and out_data hold until out_ready is seen.
module des_sbox_bank #(
  parameter int SBOX_ID = 0,
  parameter int LANES   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*LANES-1:0]   out_data,
  input  logic                 cfg_wr_en,
  input  logic                 cfg_rd_en,
  input  logic [2:0]           cfg_sbox_sel,
  input  logic [1:0]           cfg_row,
  input  logic [3:0]           cfg_col,
  input  logic [3:0]           cfg_wdata,
  output logic [3:0]           cfg_rdata,
  output logic                 cfg_rvalid,
  input  logic                 restore_req,
  output logic                 busy
);

  // Standard DES S-boxes S1..S8. Row 0 column 0 sits in the top nibble and
  // entries follow in row-major order (address = row*16 + col).
  localparam logic [255:0] SBOX_ROM [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };
  localparam logic [255:0] DEF_TABLE = SBOX_ROM[SBOX_ID];
  localparam logic [2:0]   SEL_ID    = 3'(SBOX_ID);

  function automatic logic [3:0] def_entry(input logic [5:0] idx);
    return DEF_TABLE[8'd255 - {idx, 2'b00} -: 4];
  endfunction

  typedef enum logic {ST_IDLE, ST_RESTORE} state_t;

  state_t                state;
  logic [5:0]            restore_cnt;
  logic [3:0]            tbl [64];
  logic                  sel_match;
  logic [5:0]            cfg_addr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  accept;
  logic [5:0]            lane_in;
  logic [4*LANES-1:0]    lookup_data;

  assign sel_match = (cfg_sbox_sel == SEL_ID);
  assign cfg_addr  = {cfg_row, cfg_col};
  assign busy      = (state == ST_RESTORE);
  assign wr_ok     = cfg_wr_en && sel_match && !busy;
  assign rd_ok     = cfg_rd_en && sel_match && !busy;
  assign in_ready  = !busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // Per-lane table read: row = {d[5], d[0]}, column = d[4:1].
  always_comb begin
    lane_in     = '0;
    lookup_data = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_in = in_data[6*k +: 6];
      lookup_data[4*k +: 4] = tbl[{lane_in[5], lane_in[0], lane_in[4:1]}];
    end
  end

  // Restore sequencer: walks the counter over all 64 entries, then idles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      restore_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          restore_cnt <= '0;
          if (restore_req) state <= ST_RESTORE;
        end
        ST_RESTORE: begin
          restore_cnt <= restore_cnt + 6'd1;
          if (restore_cnt == 6'd63) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Table storage: full default load on reset, one entry per restore cycle,
  // otherwise config writes. Writes are blocked while restoring.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) tbl[i] <= def_entry(6'(i));
    end else if (busy) begin
      tbl[restore_cnt] <= def_entry(restore_cnt);
    end else if (wr_ok) begin
      tbl[cfg_addr] <= cfg_wdata;
    end
  end

  // Result register: load on accept, clear on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lookup_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Config readback: one-cycle valid pulse, data holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      cfg_rvalid <= rd_ok;
      if (rd_ok) cfg_rdata <= tbl[cfg_addr];
    end
  end

endmodule

// File: tb/tb_des_sbox_bank.sv
// Bench for des_sbox_bank (S1 instance, two lanes). Stimulus tasks push
// expected results into queues; a forked monitor pops and compares them.
module tb_des_sbox_bank;

  localparam int LANES = 2;
  localparam logic [2:0] MY_ID = 3'd0;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [6*LANES-1:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [4*LANES-1:0] out_data;
  logic               cfg_wr_en = 1'b0;
  logic               cfg_rd_en = 1'b0;
  logic [2:0]         cfg_sbox_sel = '0;
  logic [1:0]         cfg_row = '0;
  logic [3:0]         cfg_col = '0;
  logic [3:0]         cfg_wdata = '0;
  logic [3:0]         cfg_rdata;
  logic               cfg_rvalid;
  logic               restore_req = 1'b0;
  logic               busy;

  // Clock
  always #5 clk = ~clk;

  des_sbox_bank #(.SBOX_ID(0), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_sbox_sel(cfg_sbox_sel),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .restore_req(restore_req), .busy(busy)
  );

  // DES S1 from FIPS 46-3, row-major.
  int s1_ref [64] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13
  };

  // Reference model state
  int         mdl_tbl [64];
  int         rest_left = 0;
  bit         mdl_ov = 1'b0;
  bit         mdl_rv = 1'b0;
  logic [7:0] exp_q [$];
  logic [3:0] rd_q [$];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_lookup(input int d6);
    int row;
    int col;
    row = ((d6 >> 5) & 1) * 2 + (d6 & 1);
    col = (d6 >> 1) & 15;
    return mdl_tbl[row * 16 + col];
  endfunction

  // Scoreboard monitor: compares whatever the DUT presents against the queues.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          if (exp_q.size() == 0) check("out_unexpected", 1, 0);
          else begin
            check(out_ready ? "out_data" : "out_hold", out_data, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (cfg_rvalid) begin
          if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
          else check("cfg_rdata", cfg_rdata, rd_q.pop_front());
        end
      end
    end
  endtask

  // One clock cycle of stimulus; updates the model and pushes expectations.
  task automatic step(input logic v, input logic [11:0] d, input logic ordy,
                      input logic wr, input logic rd, input logic [2:0] sel,
                      input logic [1:0] row, input logic [3:0] col,
                      input logic [3:0] wd, input logic rreq);
    bit exp_busy;
    bit exp_rdy;
    bit rd_next;
    int addr;
    in_valid = v; in_data = d; out_ready = ordy;
    cfg_wr_en = wr; cfg_rd_en = rd; cfg_sbox_sel = sel;
    cfg_row = row; cfg_col = col; cfg_wdata = wd; restore_req = rreq;
    @(negedge clk);
    exp_busy = (rest_left > 0);
    exp_rdy  = !exp_busy && (!mdl_ov || ordy);
    check("busy", busy, exp_busy);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, mdl_ov);
    check("cfg_rvalid", cfg_rvalid, mdl_rv);
    addr = int'(row) * 16 + int'(col);
    if (v && exp_rdy)
      exp_q.push_back({4'(ref_lookup(int'(d[11:6]))), 4'(ref_lookup(int'(d[5:0])))});
    rd_next = rd && (sel == MY_ID) && !exp_busy;
    if (rd_next) rd_q.push_back(4'(mdl_tbl[addr]));
    if (wr && (sel == MY_ID) && !exp_busy) mdl_tbl[addr] = int'(wd);
    if (exp_busy) rest_left--;
    else if (rreq) begin
      rest_left = 64;
      mdl_tbl = s1_ref;
    end
    if (v && exp_rdy) mdl_ov = 1'b1;
    else if (ordy) mdl_ov = 1'b0;
    mdl_rv = rd_next;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, ordy, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
    restore_req = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    rd_q.delete();
    mdl_tbl = s1_ref;
    rest_left = 0;
    mdl_ov = 1'b0;
    mdl_rv = 1'b0;
    check("rst_out_data", out_data, 0);
    check("rst_cfg_rdata", cfg_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mdl_tbl = s1_ref;
    fork
      monitor();
    join_none

    do_reset();

    // Known vector: lanes {63, 0} -> {13, 14}
    step(1'b1, {6'b111111, 6'b000000}, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0, 1'b0);
    idle(1'b1);

    // Backpressure: result held for three stalled cycles
    step(1'b1, {6'b100001, 6'b100001}, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 12'($urandom), 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0, 1'b0);
    idle(1'b1);

    // Random lookups with random backpressure
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 12'($urandom), $urandom_range(0, 3) != 0,
           1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0, 1'b0);
    idle(1'b1);

    // Write row0 col0 = 5 with a same-cycle lookup (old value), then new value
    step(1'b1, 12'd0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 4'd0, 4'd5, 1'b0);
    step(1'b1, 12'd0, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 4'd0, 4'd0, 1'b0);
    // Simultaneous read and write of one address
    step(1'b0, 12'd0, 1'b1, 1'b1, 1'b1, 3'd0, 2'd1, 4'd7, 4'd9, 1'b0);
    step(1'b0, 12'd0, 1'b1, 1'b0, 1'b1, 3'd0, 2'd1, 4'd7, 4'd0, 1'b0);
    idle(1'b1);

    // Random config traffic mixed with lookups
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 12'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    idle(1'b1);

    // Restore with lookups, writes, reads and repeated requests throughout
    step(1'b1, 12'($urandom), 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 70; i++)
      step(1'($urandom_range(0, 1)), 12'($urandom), 1'b1,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd0,
           2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    step(1'b1, 12'd0, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 4'd0, 4'd0, 1'b0);
    idle(1'b1);

    // Write to a different S-box id is ignored; reads for it give no pulse
    step(1'b0, 12'd0, 1'b1, 1'b1, 1'b0, 3'd3, 2'd0, 4'd0, 4'd9, 1'b0);
    step(1'b0, 12'd0, 1'b1, 1'b0, 1'b1, 3'd3, 2'd0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 12'd0, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 4'd0, 4'd0, 1'b0);
    idle(1'b1);

    // Pending result held across restore start, then reset at restore cycle 20
    step(1'b0, 12'd0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd1, 4'd2, 4'd0, 1'b0);
    step(1'b1, 12'($urandom), 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 12'($urandom), 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 20; i++)
      step(1'b1, 12'($urandom), 1'b0, 1'b1, 1'b0, 3'd0,
           2'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    do_reset();

    // Full default table readable after the aborted restore
    for (int i = 0; i < 64; i++)
      step(1'b1, 12'($urandom), 1'b1, 1'b0, 1'b1, 3'd0, 2'(i / 16), 4'(i % 16), 4'd0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_sbox_bank.md
DES_SBOX_BANK -- requirements
Module: des_sbox_bank

Interface
REQ-001 Parameter SBOX_ID, default 0, meaning: selects which FIPS 46-3 DES S-box (S1..S8 = 0..7) this instance holds and answers to on the config port.
REQ-002 Parameter LANES, default 1, meaning: number of parallel lookup lanes sharing one table (range 1..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 in_valid  input  1  lookup request valid.
REQ-006 in_ready  output  1  block accepts lookup this cycle.
REQ-007 in_data  input  6*LANES  lane k uses bits [6k+5:6k].
REQ-008 out_valid  output  1  out_data holds a result.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_data  output  4*LANES  lane k result at bits [4k+3:4k].
REQ-011 cfg_wr_en  input  1  table write strobe.
REQ-012 cfg_rd_en  input  1  table readback strobe.
REQ-013 cfg_sbox_sel  input  3  target S-box; write/read acts only when equal to SBOX_ID.
REQ-014 cfg_row  input  2  table row.
REQ-015 cfg_col  input  4  table column.
REQ-016 cfg_wdata  input  4  new entry value.
REQ-017 cfg_rdata  output  4  readback value.
REQ-018 cfg_rvalid  output  1  one-cycle pulse, cfg_rdata valid.
REQ-019 restore_req  input  1  request reload of default table.
REQ-020 busy  output  1  restore sequence in progress.

Function
REQ-021 Table: 64 x 4-bit entries, address = row*16 + col; lookup row = {d[5],d[0]}, col = d[4:1].
REQ-022 Default contents: standard DES S-box number SBOX_ID+1 from FIPS 46-3.
REQ-023 in_ready = !busy && (!out_valid || out_ready).
REQ-024 Lookup accepted when in_valid && in_ready; all lanes' results are registered into out_data with out_valid=1 on the next edge (latency 1).
REQ-025 out_valid/out_data hold stable while out_valid && !out_ready; out_valid clears on out_ready with no new accept; accept and drain in the same cycle give back-to-back results (throughput 1/cycle).
REQ-026 Config write: cfg_wr_en && sel match && !busy writes cfg_wdata at (cfg_row,cfg_col) on the edge; it is ignored otherwise.
REQ-027 Lookup of the same entry accepted in the same cycle as a write returns the old value; lookups accepted on later cycles return the new value.
REQ-028 Readback: cfg_rd_en && sel match && !busy gives cfg_rdata = entry and cfg_rvalid=1 on the next cycle; cfg_rvalid is 0 otherwise and cfg_rdata holds its last value.
REQ-029 Simultaneous read and write of the same address: both take effect, and readback returns the old value.
REQ-030 FSM IDLE/RESTORE: restore_req in IDLE sets busy=1 next cycle; RESTORE writes default entry i at cycle i (i=0..63, 6-bit counter); after entry 63 it returns to IDLE with busy=0; the sequence lasts exactly 64 cycles.
REQ-031 restore_req during RESTORE is ignored; the counter does not restart.
REQ-032 A result already in out_valid when restore starts is kept until drained; no new accepts are taken while busy.
REQ-033 Lanes are independent; identical lane inputs produce identical results.

Reset
REQ-034 rst_n=0 at an edge: table loaded with default contents in that cycle; FSM=IDLE, counter=0, busy=0, out_valid=0, out_data=0, cfg_rvalid=0, cfg_rdata=0.
REQ-035 Reset mid-restore or with a result pending aborts the operation: the full default table is in place and the pending result is discarded after the reset edge.
REQ-036 in_ready=1 on the first cycle after reset is released.

Verification
REQ-037 SBOX_ID=0, LANES=2, in_data={6'b111111,6'b000000}, out_ready=1 -> next cycle out_valid=1, out_data={4'd13,4'd14}.
REQ-038 Input 6'b100001 with out_ready=0 for 3 cycles -> out_data=15 held stable, in_ready=0 until out_ready=1.
REQ-039 Write row0 col0=5 (sel=0), lookup 6'b000000 in the same cycle -> 14; lookup on the next cycle -> 5; readback -> cfg_rdata=5, cfg_rvalid pulse.
REQ-040 Write with cfg_sbox_sel=3 on an instance with SBOX_ID=0 -> table unchanged, readback row0 col0 = 14.
REQ-041 After an edit, pulse restore_req -> busy=1 for exactly 64 cycles, in_ready=0 and writes ignored throughout; afterwards lookup 6'b000000 -> 14.
REQ-042 Assert rst_n=0 at restore cycle 20 -> next cycle busy=0, out_valid=0, full default table readable.
